// File: rtl/multicycle_main_control_if.sv
// Unified-memory request/ready handshake between the main control FSM and memory.
// The controller (master) drives the request, its direction and the address select.
// Memory (slave) answers with mem_ready.
interface multicycle_main_control_if;
  logic mem_req;    // request valid
  logic mem_read;   // read request
  logic mem_write;  // write request
  logic iord;       // address select: 0 = PC, 1 = ALUOut
  logic mem_ready;  // write accepted / read data returned this cycle

  modport master (
    output mem_req, mem_read, mem_write, iord,
    input  mem_ready
  );

  modport slave (
    input  mem_req, mem_read, mem_write, iord,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_main_control.sv
// Moore main control FSM for the multicycle RV32 datapath.
// Each instruction runs through fetch, decode, execute, memory and writeback.
// Memory accesses use a ready handshake on a single unified memory.
// aluop to the ALU-control decoder: 00 = add, 01 = subtract, 10 = use funct7/funct3.
// Optional feature (macro MC_PERF_COUNTERS_EN) adds two 32-bit counters:
//   cycle_count counts active cycles; instret counts retired instructions.
module multicycle_main_control #(
  parameter bit RESET_STATE_FETCH = 1'b1  // 1: reset into FETCH, 0: reset into IDLE and wait for start
) (
  input  logic       clk,
  input  logic       reset,               // synchronous, active-high
  input  logic       start,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  multicycle_main_control_if.master mem,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic       pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] aluop,
  output logic       reg_write,
  output logic [1:0] mem_to_reg,
  output logic       illegal_instr,
  output logic [3:0] state_o
`ifdef MC_PERF_COUNTERS_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instret
`endif
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC_R    = 4'd7,
    S_EXEC_I    = 4'd8,
    S_ALU_WB    = 4'd9,
    S_BRANCH    = 4'd10,
    S_JAL       = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  localparam state_t RESET_STATE = RESET_STATE_FETCH ? S_FETCH : S_IDLE;

  state_t r_state;
  state_t w_next;
  logic   w_branch_ok;  // funct3 names a supported branch (beq/bne)

  assign w_branch_ok = (funct3 == 3'b000) || (funct3 == 3'b001);
  assign state_o     = r_state;

  // State register; reset wins over every other input, including a pending handshake.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) r_state <= RESET_STATE;
    else       r_state <= w_next;
  end

  // Next-state decode from the current state, opcode, funct3 and memory ready.
  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (start) w_next = S_FETCH;
      S_FETCH:     if (mem.mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          7'b0000011, 7'b0100011: w_next = S_MEM_ADDR;
          7'b0110011:             w_next = S_EXEC_R;
          7'b0010011:             w_next = S_EXEC_I;
          7'b1100011:             w_next = S_BRANCH;
          7'b1101111:             w_next = S_JAL;
          default:                w_next = S_TRAP;
        endcase
      end
      S_MEM_ADDR:  w_next = opcode[5] ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem.mem_ready) w_next = S_MEM_WB;
      S_MEM_WB:    w_next = S_FETCH;
      S_MEM_WRITE: if (mem.mem_ready) w_next = S_FETCH;
      S_EXEC_R:    w_next = S_ALU_WB;
      S_EXEC_I:    w_next = S_ALU_WB;
      S_ALU_WB:    w_next = S_FETCH;
      S_BRANCH:    w_next = w_branch_ok ? S_FETCH : S_TRAP;
      S_JAL:       w_next = S_FETCH;
      S_TRAP:      w_next = S_TRAP;  // only reset leaves the trap
      default:     w_next = S_TRAP;  // unused encodings are treated as a fault
    endcase
  end

  // Moore outputs. Only FETCH looks at mem_ready and only BRANCH looks at funct3.
  // The request, its direction and iord depend on state alone, so they hold steady
  // until the handshake completes.
  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_read  = 1'b0;
    mem.mem_write = 1'b0;
    mem.iord      = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_src        = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    aluop         = 2'b00;
    reg_write     = 1'b0;
    mem_to_reg    = 2'b00;
    illegal_instr = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem.mem_req  = 1'b1;
        mem.mem_read = 1'b1;
        alu_src_b    = 2'b01;           // PC + 4
        ir_write     = mem.mem_ready;
        pc_write     = mem.mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;              // old_pc + imm: branch/jump target into ALUOut
        alu_src_b = 2'b10;
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        mem.mem_req  = 1'b1;
        mem.mem_read = 1'b1;
        mem.iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
      end
      S_MEM_WRITE: begin
        mem.mem_req   = 1'b1;
        mem.mem_write = 1'b1;
        mem.iord      = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        aluop     = 2'b10;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
      end
      S_ALU_WB:  reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a     = 2'b10;
        aluop         = 2'b01;
        pc_src        = 1'b1;
        pc_write_cond = w_branch_ok;    // no PC update on an unsupported funct3
        branch_ne     = w_branch_ok & funct3[0];
      end
      S_JAL: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b10;
        pc_write   = 1'b1;
        pc_src     = 1'b1;
      end
      S_TRAP:    illegal_instr = 1'b1;  // sticky because TRAP is only left by reset
      default: ;
    endcase
  end

`ifdef MC_PERF_COUNTERS_EN
  logic [31:0] r_cycle_count;
  logic [31:0] r_instret;
  logic        w_active;
  logic        w_retire;

  assign w_active = (r_state != S_IDLE) && (r_state != S_TRAP);
  assign w_retire = (w_next == S_FETCH) &&
                    (r_state inside {S_MEM_WB, S_MEM_WRITE, S_ALU_WB, S_BRANCH, S_JAL});

  // Active-cycle and retired-instruction counters; both wrap modulo 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_count <= 32'd0;
      r_instret     <= 32'd0;
    end else begin
      if (w_active) r_cycle_count <= r_cycle_count + 32'd1;
      if (w_retire) r_instret     <= r_instret + 32'd1;
    end
  end

  assign cycle_count = r_cycle_count;
  assign instret     = r_instret;
`endif

endmodule

// File: tb/tb_multicycle_main_control.sv
// Self-checking bench for multicycle_main_control.
// Directed per-cycle vectors push the expected state and outputs into a scoreboard.
// A negedge monitor pops each entry and compares it against the DUT.
module tb_multicycle_main_control;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  typedef struct packed {
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       pc_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       illegal;
  } outs_t;

  typedef struct {
    int          id;
    logic [3:0]  st;
    outs_t       o;
    logic [31:0] cyc;
    logic [31:0] ret;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        ir_write, pc_write, pc_write_cond, branch_ne, pc_src;
  logic [1:0]  alu_src_a, alu_src_b, aluop, mem_to_reg;
  logic        reg_write, illegal_instr;
  logic [3:0]  state_o;
`ifdef MC_PERF_COUNTERS_EN
  logic [31:0] cycle_count, instret;
`endif

  multicycle_main_control_if bus ();

  multicycle_main_control dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .opcode        (opcode),
    .funct3        (funct3),
    .mem           (bus.master),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .branch_ne     (branch_ne),
    .pc_src        (pc_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .aluop         (aluop),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .illegal_instr (illegal_instr),
    .state_o       (state_o)
`ifdef MC_PERF_COUNTERS_EN
    ,
    .cycle_count   (cycle_count),
    .instret       (instret)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pushed = 0;

  // Reference counter model and previous-cycle bookkeeping.
  logic [31:0] m_cyc = 32'd0;
  logic [31:0] m_ret = 32'd0;
  int          prev_state = 0;
  logic        prev_rst = 1'b0;
  bit          prev_valid = 1'b0;

  // Expected Moore outputs for a state, written out from the control table.
  function automatic outs_t exp_out(int s, logic rdy, logic [2:0] f3);
    outs_t o;
    o = '0;
    case (s)
      1:  begin o.mem_req = 1; o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
      2:  begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; end
      3:  begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b10; end
      4:  begin o.mem_req = 1; o.mem_read = 1; o.iord = 1; end
      5:  begin o.reg_write = 1; o.mem_to_reg = 2'b01; end
      6:  begin o.mem_req = 1; o.mem_write = 1; o.iord = 1; end
      7:  begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b00; o.aluop = 2'b10; end
      8:  begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b10; end
      9:  begin o.reg_write = 1; end
      10: begin
        o.alu_src_a = 2'b10; o.aluop = 2'b01; o.pc_src = 1;
        if (f3 == 3'b000 || f3 == 3'b001) begin
          o.pc_write_cond = 1; o.branch_ne = f3[0];
        end
      end
      11: begin o.reg_write = 1; o.mem_to_reg = 2'b10; o.pc_write = 1; o.pc_src = 1; end
      12: begin o.illegal = 1; end
      default: ;
    endcase
    return o;
  endfunction

  // One clock cycle of stimulus; pushes what the DUT must show during this cycle.
  task automatic step(input logic rst, input logic st, input logic [6:0] opc,
                      input logic [2:0] f3, input logic rdy, input int exp_state,
                      input bit chk);
    exp_t e;
    if (prev_rst) begin
      m_cyc = 32'd0;
      m_ret = 32'd0;
    end else if (prev_valid) begin
      if (prev_state != 0 && prev_state != 12) m_cyc = m_cyc + 32'd1;
      if (exp_state == 1 && prev_state inside {5, 6, 9, 10, 11}) m_ret = m_ret + 32'd1;
    end
    reset         = rst;
    start         = st;
    opcode        = opc;
    funct3        = f3;
    bus.mem_ready = rdy;
    if (chk) begin
      e.id  = n_pushed;
      e.st  = exp_state[3:0];
      e.o   = exp_out(exp_state, rdy, f3);
      e.cyc = m_cyc;
      e.ret = m_ret;
      sb.push_back(e);
      n_pushed++;
    end
    prev_state = exp_state;
    prev_rst   = rst;
    prev_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the DUT against the oldest expected entry, mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t  e;
      outs_t act;
      e = sb.pop_front();
      act = '{mem_req: bus.mem_req, mem_read: bus.mem_read, mem_write: bus.mem_write,
              iord: bus.iord, ir_write: ir_write, pc_write: pc_write,
              pc_write_cond: pc_write_cond, branch_ne: branch_ne, pc_src: pc_src,
              alu_src_a: alu_src_a, alu_src_b: alu_src_b, aluop: aluop,
              reg_write: reg_write, mem_to_reg: mem_to_reg, illegal: illegal_instr};
      n_checks++;
      if (state_o !== e.st) begin
        n_fail++;
        $display("FAIL entry%0d state: got %0d want %0d", e.id, state_o, e.st);
      end
      n_checks++;
      if (act !== e.o) begin
        n_fail++;
        $display("FAIL entry%0d outputs(state %0d): got %05h want %05h", e.id, e.st, act, e.o);
      end
`ifdef MC_PERF_COUNTERS_EN
      n_checks++;
      if (cycle_count !== e.cyc) begin
        n_fail++;
        $display("FAIL entry%0d cycle_count: got %0d want %0d", e.id, cycle_count, e.cyc);
      end
      n_checks++;
      if (instret !== e.ret) begin
        n_fail++;
        $display("FAIL entry%0d instret: got %0d want %0d", e.id, instret, e.ret);
      end
`endif
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; opcode = '0; funct3 = '0; bus.mem_ready = 1'b1;

    // Reset held two cycles: state before the first edge is unknown.
    step(1, 0, 7'd0, 3'd0, 1, 0, 0);
    step(1, 0, 7'd0, 3'd0, 1, 1, 1);

    // R-type: FETCH, DECODE, EXEC_R, ALU_WB.
    step(0, 0, OP_R, 3'd0, 1, 1, 1);
    step(0, 0, OP_R, 3'd0, 1, 2, 1);
    step(0, 0, OP_R, 3'd0, 1, 7, 1);
    step(0, 0, OP_R, 3'd0, 1, 9, 1);

    // addi: FETCH, DECODE, EXEC_I, ALU_WB.
    step(0, 0, OP_I, 3'd0, 1, 1, 1);
    step(0, 0, OP_I, 3'd0, 1, 2, 1);
    step(0, 0, OP_I, 3'd0, 1, 8, 1);
    step(0, 0, OP_I, 3'd0, 1, 9, 1);

    // lw with two memory wait cycles in MEM_READ.
    step(0, 0, OP_LOAD, 3'd2, 1, 1, 1);
    step(0, 0, OP_LOAD, 3'd2, 1, 2, 1);
    step(0, 0, OP_LOAD, 3'd2, 1, 3, 1);
    step(0, 0, OP_LOAD, 3'd2, 0, 4, 1);
    step(0, 0, OP_LOAD, 3'd2, 0, 4, 1);
    step(0, 0, OP_LOAD, 3'd2, 1, 4, 1);
    step(0, 0, OP_LOAD, 3'd2, 1, 5, 1);

    // sw with one fetch wait cycle.
    step(0, 0, OP_STORE, 3'd2, 0, 1, 1);
    step(0, 0, OP_STORE, 3'd2, 1, 1, 1);
    step(0, 0, OP_STORE, 3'd2, 0, 2, 1);
    step(0, 0, OP_STORE, 3'd2, 1, 3, 1);
    step(0, 0, OP_STORE, 3'd2, 1, 6, 1);

    // beq, then bne.
    step(0, 0, OP_BRANCH, 3'b000, 1, 1, 1);
    step(0, 0, OP_BRANCH, 3'b000, 0, 2, 1);
    step(0, 0, OP_BRANCH, 3'b000, 1, 10, 1);
    step(0, 0, OP_BRANCH, 3'b001, 1, 1, 1);
    step(0, 0, OP_BRANCH, 3'b001, 1, 2, 1);
    step(0, 0, OP_BRANCH, 3'b001, 0, 10, 1);

    // jal.
    step(0, 0, OP_JAL, 3'd0, 1, 1, 1);
    step(0, 0, OP_JAL, 3'd0, 1, 2, 1);
    step(0, 0, OP_JAL, 3'd0, 1, 11, 1);

    // Illegal opcode: TRAP persists with mem_ready toggling, then reset recovers.
    step(0, 0, OP_BAD, 3'd0, 1, 1, 1);
    step(0, 0, OP_BAD, 3'd0, 1, 2, 1);
    for (int i = 0; i < 10; i++) step(0, 0, OP_BAD, 3'd0, logic'(i % 2), 12, 1);
    step(1, 0, OP_BAD, 3'd0, 1, 12, 1);

    // Branch with unsupported funct3: no conditional PC load, then TRAP.
    step(0, 0, OP_BRANCH, 3'b010, 1, 1, 1);
    step(0, 0, OP_BRANCH, 3'b010, 1, 2, 1);
    step(0, 0, OP_BRANCH, 3'b010, 1, 10, 1);
    step(0, 0, OP_BRANCH, 3'b010, 1, 12, 1);
    step(1, 0, OP_BRANCH, 3'b010, 1, 12, 1);

    // Reset asserted while MEM_WRITE waits on memory.
    step(0, 0, OP_STORE, 3'd2, 1, 1, 1);
    step(0, 0, OP_STORE, 3'd2, 1, 2, 1);
    step(0, 0, OP_STORE, 3'd2, 0, 3, 1);
    step(0, 0, OP_STORE, 3'd2, 0, 6, 1);
    step(1, 0, OP_STORE, 3'd2, 0, 6, 1);
    step(0, 0, OP_STORE, 3'd2, 0, 1, 1);
    step(0, 0, OP_STORE, 3'd2, 1, 1, 1);

    // Let the monitor drain, with a bounded wait.
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
